// File: rtl/cmd_frame_aligner.sv
// Serial command receiver. It shifts in one bit per clock, MSB first, and hunts for the sync frame.
// After enough aligned syncs it locks and emits 16-bit frames with lock status and a lock-loss count.
module cmd_frame_aligner #(
    parameter logic [15:0] SYNC_PATTERN   = 16'h817E,
    parameter int          LOCK_SYNCS     = 16,
    parameter int          TIMEOUT_FRAMES = 32
) (
    input  logic        CLK,
    input  logic        RESETB,
    input  logic        CMD_IN,
    input  logic        CLEAR_CNT,
    output logic [15:0] FRAME,
    output logic        FRAME_VALID,
    output logic        FRAME_IS_SYNC,
    output logic        LOCKED,
    output logic [7:0]  LOCK_LOSS_CNT
);

    typedef enum logic [1:0] {
        S_HUNT,
        S_VERIFY,
        S_LOCKED
    } state_t;

    localparam logic [7:0] LOCK_N    = 8'(LOCK_SYNCS);
    localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT_FRAMES);

    state_t      r_state;
    logic [15:0] r_sr;
    logic [3:0]  r_phase;
    logic [7:0]  r_syncCnt;
    logic [7:0]  r_missCnt;

    logic w_isSync;
    logic w_boundary;
    logic w_lossEvent;

    // r_sr holds a complete aligned frame in the cycle where r_phase wraps.
    assign w_isSync    = (r_sr == SYNC_PATTERN);
    assign w_boundary  = (r_phase == 4'd15);
    assign w_lossEvent = (r_state == S_LOCKED) && w_boundary && !w_isSync &&
                         ((r_missCnt + 8'd1) == TIMEOUT_N);

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state       <= S_HUNT;
            r_sr          <= 16'h0000;
            r_phase       <= 4'd0;
            r_syncCnt     <= 8'd0;
            r_missCnt     <= 8'd0;
            FRAME         <= 16'h0000;
            FRAME_VALID   <= 1'b0;
            FRAME_IS_SYNC <= 1'b0;
            LOCKED        <= 1'b0;
            LOCK_LOSS_CNT <= 8'd0;
        end else begin
            r_sr        <= {r_sr[14:0], CMD_IN};
            r_phase     <= r_phase + 4'd1;
            FRAME_VALID <= 1'b0;

            // A clear takes priority over a lock loss on the same edge.
            if (CLEAR_CNT) begin
                LOCK_LOSS_CNT <= 8'd0;
            end else if (w_lossEvent && (LOCK_LOSS_CNT != 8'hFF)) begin
                LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
            end

            case (r_state)
                S_HUNT: begin
                    if (w_isSync) begin
                        r_phase   <= 4'd0;
                        r_syncCnt <= 8'd1;
                        r_missCnt <= 8'd0;
                        if (LOCK_N == 8'd1) begin
                            r_state <= S_LOCKED;
                            LOCKED  <= 1'b1;
                        end else begin
                            r_state <= S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    if (w_boundary) begin
                        if (w_isSync) begin
                            r_syncCnt <= r_syncCnt + 8'd1;
                            if ((r_syncCnt + 8'd1) == LOCK_N) begin
                                r_state   <= S_LOCKED;
                                r_missCnt <= 8'd0;
                                LOCKED    <= 1'b1;
                            end
                        end else begin
                            r_state   <= S_HUNT;
                            r_syncCnt <= 8'd0;
                        end
                    end
                end
                S_LOCKED: begin
                    // An off-phase sync is ignored here; only a timeout can realign.
                    if (w_boundary) begin
                        FRAME         <= r_sr;
                        FRAME_VALID   <= 1'b1;
                        FRAME_IS_SYNC <= w_isSync;
                        if (w_isSync) begin
                            r_missCnt <= 8'd0;
                        end else if (w_lossEvent) begin
                            r_state   <= S_HUNT;
                            r_missCnt <= 8'd0;
                            r_syncCnt <= 8'd0;
                            LOCKED    <= 1'b0;
                        end else begin
                            r_missCnt <= r_missCnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_aligner.sv
// Directed bench for cmd_frame_aligner: a default instance and a short-lock instance (LOCK_SYNCS=1, TIMEOUT_FRAMES=2)
// that quickly exercises lock-loss counter saturation and clear.
module tb_cmd_frame_aligner;

    localparam logic [15:0] SYNC = 16'h817E;

    logic        clk;
    logic        resetb;
    logic        cmdIn;
    logic        clearCnt;
    logic [15:0] frame;
    logic        frameValid;
    logic        frameIsSync;
    logic        locked;
    logic [7:0]  lossCnt;

    logic        cmdIn2;
    logic        clearCnt2;
    logic [15:0] frame2;
    logic        frameValid2;
    logic        frameIsSync2;
    logic        locked2;
    logic [7:0]  lossCnt2;

    int          testsRun;
    int          testsFailed;
    int          bitIdx;
    int          validCnt;
    int          lastValidBit;
    int          lockRiseBit;
    logic [15:0] lastFrame;
    logic        lastSync;
    logic        lastLocked;
    logic        prevLocked;
    logic        lockedEver;

    cmd_frame_aligner dut (
        .CLK(clk), .RESETB(resetb), .CMD_IN(cmdIn), .CLEAR_CNT(clearCnt),
        .FRAME(frame), .FRAME_VALID(frameValid), .FRAME_IS_SYNC(frameIsSync),
        .LOCKED(locked), .LOCK_LOSS_CNT(lossCnt)
    );

    cmd_frame_aligner #(.SYNC_PATTERN(16'h817E), .LOCK_SYNCS(1), .TIMEOUT_FRAMES(2)) dut2 (
        .CLK(clk), .RESETB(resetb), .CMD_IN(cmdIn2), .CLEAR_CNT(clearCnt2),
        .FRAME(frame2), .FRAME_VALID(frameValid2), .FRAME_IS_SYNC(frameIsSync2),
        .LOCKED(locked2), .LOCK_LOSS_CNT(lossCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearTracking();
        bitIdx       = 0;
        validCnt     = 0;
        lastValidBit = -1;
        lockRiseBit  = -1;
        lastFrame    = 16'h0000;
        lastSync     = 1'b0;
        lastLocked   = 1'b0;
        prevLocked   = 1'b0;
        lockedEver   = 1'b0;
    endtask

    task automatic doReset();
        resetb    = 1'b0;
        cmdIn     = 1'b0;
        cmdIn2    = 1'b0;
        clearCnt  = 1'b0;
        clearCnt2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
        clearTracking();
    endtask

    // Bit n is sampled at edge n; the strobe for a frame shows up after the next edge.
    task automatic sendBit(input logic b);
        cmdIn = b;
        @(posedge clk);
        #1;
        bitIdx++;
        if (frameValid) begin
            validCnt++;
            lastValidBit = bitIdx;
            lastFrame    = frame;
            lastSync     = frameIsSync;
            lastLocked   = locked;
        end
        if (locked) lockedEver = 1'b1;
        if (locked && !prevLocked) lockRiseBit = bitIdx;
        prevLocked = locked;
    endtask

    task automatic sendFrame(input logic [15:0] f);
        for (int i = 15; i >= 0; i--) sendBit(f[i]);
    endtask

    task automatic sendFrames(input logic [15:0] f, input int n);
        for (int k = 0; k < n; k++) sendFrame(f);
    endtask

    task automatic sendFrame2(input logic [15:0] f, input logic clrFirst);
        for (int i = 15; i >= 0; i--) begin
            cmdIn2    = f[i];
            clearCnt2 = (i == 15) ? clrFirst : 1'b0;
            @(posedge clk);
            #1;
        end
        clearCnt2 = 1'b0;
    endtask

    task automatic test_reset();
        resetb    = 1'b0;
        cmdIn     = 1'b1;
        cmdIn2    = 1'b1;
        clearCnt  = 1'b0;
        clearCnt2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++; if (frame !== 16'h0000) begin testsFailed++; $display("[TB] FAIL reset_frame: got %h, expected 0000", frame); end
        testsRun++; if (frameValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %b, expected 0", frameValid); end
        testsRun++; if (frameIsSync !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_is_sync: got %b, expected 0", frameIsSync); end
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_locked: got %b, expected 0", locked); end
        testsRun++; if (lossCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_loss_cnt: got %0d, expected 0", lossCnt); end
        testsRun++; if (locked2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_locked2: got %b, expected 0", locked2); end
        resetb = 1'b1;
    endtask

    task automatic test_lock_offset();
        doReset();
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
        sendFrames(SYNC, 16);
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL lock_not_yet: got %b, expected 0", locked); end
        testsRun++; if (validCnt !== 0) begin testsFailed++; $display("[TB] FAIL no_valid_before_lock: got %0d, expected 0", validCnt); end
        sendFrame(16'hA5A5);
        testsRun++; if (lockRiseBit !== 262) begin testsFailed++; $display("[TB] FAIL lock_rise_bit: got %0d, expected 262", lockRiseBit); end
        testsRun++; if (validCnt !== 0) begin testsFailed++; $display("[TB] FAIL no_valid_in_17th: got %0d, expected 0", validCnt); end
    endtask

    task automatic test_frame_emission();
        sendFrame(SYNC);
        testsRun++; if (validCnt !== 1) begin testsFailed++; $display("[TB] FAIL emit1_count: got %0d, expected 1", validCnt); end
        testsRun++; if (lastValidBit !== 278) begin testsFailed++; $display("[TB] FAIL emit1_time: got %0d, expected 278", lastValidBit); end
        testsRun++; if (lastFrame !== 16'hA5A5) begin testsFailed++; $display("[TB] FAIL emit1_frame: got %h, expected a5a5", lastFrame); end
        testsRun++; if (lastSync !== 1'b0) begin testsFailed++; $display("[TB] FAIL emit1_sync: got %b, expected 0", lastSync); end
        testsRun++; if (lastLocked !== 1'b1) begin testsFailed++; $display("[TB] FAIL emit1_locked: got %b, expected 1", lastLocked); end
        sendFrame(16'h1234);
        testsRun++; if (validCnt !== 2) begin testsFailed++; $display("[TB] FAIL emit2_count: got %0d, expected 2", validCnt); end
        testsRun++; if (lastValidBit !== 294) begin testsFailed++; $display("[TB] FAIL emit2_time: got %0d, expected 294", lastValidBit); end
        testsRun++; if (lastFrame !== SYNC) begin testsFailed++; $display("[TB] FAIL emit2_frame: got %h, expected 817e", lastFrame); end
        testsRun++; if (lastSync !== 1'b1) begin testsFailed++; $display("[TB] FAIL emit2_sync: got %b, expected 1", lastSync); end
        sendFrame(SYNC);
        testsRun++; if (validCnt !== 3) begin testsFailed++; $display("[TB] FAIL emit3_count: got %0d, expected 3", validCnt); end
        testsRun++; if (lastValidBit !== 310) begin testsFailed++; $display("[TB] FAIL emit3_time: got %0d, expected 310", lastValidBit); end
        testsRun++; if (lastFrame !== 16'h1234) begin testsFailed++; $display("[TB] FAIL emit3_frame: got %h, expected 1234", lastFrame); end
        testsRun++; if (lastSync !== 1'b0) begin testsFailed++; $display("[TB] FAIL emit3_sync: got %b, expected 0", lastSync); end
    endtask

    task automatic test_timeout();
        validCnt = 0;
        sendFrames(16'h6969, 32);
        testsRun++; if (validCnt !== 32) begin testsFailed++; $display("[TB] FAIL timeout_strobes: got %0d, expected 32", validCnt); end
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_still_locked: got %b, expected 1", locked); end
        testsRun++; if (lossCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL timeout_loss_before: got %0d, expected 0", lossCnt); end
        sendBit(1'b0);
        testsRun++; if (validCnt !== 33) begin testsFailed++; $display("[TB] FAIL timeout_last_strobe: got %0d, expected 33", validCnt); end
        testsRun++; if (lastFrame !== 16'h6969) begin testsFailed++; $display("[TB] FAIL timeout_frame: got %h, expected 6969", lastFrame); end
        testsRun++; if (lastLocked !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_locked_at_strobe: got %b, expected 0", lastLocked); end
        testsRun++; if (lossCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL timeout_loss_cnt: got %0d, expected 1", lossCnt); end
    endtask

    task automatic test_timeout_rescue();
        doReset();
        sendFrames(SYNC, 16);
        sendFrames(16'h6969, 30);
        sendFrame(SYNC);
        sendFrames(16'h6969, 31);
        sendBit(1'b0);
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL rescue_locked: got %b, expected 1", locked); end
        testsRun++; if (lossCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL rescue_loss_cnt: got %0d, expected 0", lossCnt); end
        testsRun++; if (lastFrame !== 16'h6969) begin testsFailed++; $display("[TB] FAIL rescue_frame: got %h, expected 6969", lastFrame); end
    endtask

    task automatic test_broken_verify();
        doReset();
        sendFrames(SYNC, 3);
        sendFrame(16'h0000);
        sendFrames(SYNC, 15);
        testsRun++; if (lockedEver !== 1'b0) begin testsFailed++; $display("[TB] FAIL broken_never_locked: got %b, expected 0", lockedEver); end
        sendFrame(SYNC);
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL broken_not_yet: got %b, expected 0", locked); end
        sendBit(1'b0);
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL broken_relock: got %b, expected 1", locked); end
    endtask

    task automatic test_bit_slip();
        doReset();
        sendFrames(SYNC, 17);
        sendBit(1'b0);
        sendFrames(SYNC, 31);
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL slip_still_locked: got %b, expected 1", locked); end
        testsRun++; if (lastSync !== 1'b0) begin testsFailed++; $display("[TB] FAIL slip_garbage: got %b, expected 0", lastSync); end
        sendFrame(SYNC);
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL slip_lost: got %b, expected 0", locked); end
        testsRun++; if (lossCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL slip_loss_cnt: got %0d, expected 1", lossCnt); end
        sendFrames(SYNC, 15);
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL slip_not_relocked: got %b, expected 0", locked); end
        sendFrame(SYNC);
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL slip_relocked: got %b, expected 1", locked); end
        sendFrame(16'h1234);
        testsRun++; if (lastFrame !== SYNC) begin testsFailed++; $display("[TB] FAIL slip_new_phase: got %h, expected 817e", lastFrame); end
        sendBit(1'b0);
        testsRun++; if (lastFrame !== 16'h1234) begin testsFailed++; $display("[TB] FAIL slip_data_frame: got %h, expected 1234", lastFrame); end
        testsRun++; if (lossCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL slip_loss_final: got %0d, expected 1", lossCnt); end
    endtask

    task automatic test_async_reset();
        doReset();
        sendFrames(SYNC, 18);
        for (int i = 15; i >= 9; i--) sendBit(SYNC[i]);
        testsRun++; if (locked !== 1'b1 || frameIsSync !== 1'b1) begin testsFailed++; $display("[TB] FAIL areset_precondition: got locked=%b is_sync=%b, expected 1 1", locked, frameIsSync); end
        #2;
        resetb = 1'b0;
        #1;
        testsRun++; if (locked !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_locked: got %b, expected 0", locked); end
        testsRun++; if (frame !== 16'h0000) begin testsFailed++; $display("[TB] FAIL areset_frame: got %h, expected 0000", frame); end
        testsRun++; if (frameIsSync !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_is_sync: got %b, expected 0", frameIsSync); end
        repeat (3) @(posedge clk);
        #1;
        resetb = 1'b1;
        clearTracking();
        sendFrames(SYNC, 16);
        testsRun++; if (lockedEver !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_no_early_lock: got %b, expected 0", lockedEver); end
        sendFrame(SYNC);
        testsRun++; if (locked !== 1'b1) begin testsFailed++; $display("[TB] FAIL areset_relock: got %b, expected 1", locked); end
    endtask

    task automatic test_loss_counter();
        doReset();
        sendFrame2(SYNC, 1'b0);
        sendFrame2(16'h0000, 1'b0);
        testsRun++; if (locked2 !== 1'b1) begin testsFailed++; $display("[TB] FAIL short_lock: got %b, expected 1", locked2); end
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(SYNC, 1'b0);
        testsRun++; if (lossCnt2 !== 8'd1 || locked2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL short_first_loss: got cnt=%0d locked=%b, expected 1 0", lossCnt2, locked2); end
        for (int k = 0; k < 254; k++) begin
            sendFrame2(16'h0000, 1'b0);
            sendFrame2(16'h0000, 1'b0);
            sendFrame2(SYNC, 1'b0);
        end
        testsRun++; if (lossCnt2 !== 8'd255) begin testsFailed++; $display("[TB] FAIL sat_reach: got %0d, expected 255", lossCnt2); end
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(SYNC, 1'b0);
        testsRun++; if (lossCnt2 !== 8'd255) begin testsFailed++; $display("[TB] FAIL sat_hold: got %0d, expected 255", lossCnt2); end
        sendFrame2(16'h0000, 1'b1);
        testsRun++; if (lossCnt2 !== 8'd0) begin testsFailed++; $display("[TB] FAIL clear_plain: got %0d, expected 0", lossCnt2); end
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(SYNC, 1'b0);
        testsRun++; if (lossCnt2 !== 8'd1) begin testsFailed++; $display("[TB] FAIL count_after_clear: got %0d, expected 1", lossCnt2); end
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(16'h0000, 1'b0);
        sendFrame2(SYNC, 1'b1);
        testsRun++; if (lossCnt2 !== 8'd0) begin testsFailed++; $display("[TB] FAIL clear_wins: got %0d, expected 0", lossCnt2); end
        testsRun++; if (locked2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL clear_loss_locked: got %b, expected 0", locked2); end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        clearTracking();
        test_reset();
        test_lock_offset();
        test_frame_emission();
        test_timeout();
        test_timeout_rescue();
        test_broken_verify();
        test_bit_slip();
        test_async_reset();
        test_loss_counter();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cmd_frame_aligner.md
Name: cmd_frame_aligner

Overview:
- Chip-side receiver for the serial command stream that the FPGA command encoder drives onto LVDS_CMD.
- Deserializes one bit per clock, MSB first, into 16-bit frames.
- Hunts for and verifies the sync frame alignment, then emits aligned frames with lock status and a lock-loss counter.
- Sits in the monopix2 command path, between the LVDS_CMD pad and the command decoder.

Parameters:
- SYNC_PATTERN, 16'h817E, sync frame value.
- LOCK_SYNCS, 16, aligned sync frames required to lock, counting the hunt hit. Legal range 1..255.
- TIMEOUT_FRAMES, 32, consecutive non-sync frames while locked that force loss of lock. Legal range 2..255.

Ports:
- CLK  input  1  command clock (CLKCMD domain); one serial bit per rising edge.
- RESETB  input  1  asynchronous, active-low reset.
- CMD_IN  input  1  serial command bit, sampled on every rising edge of CLK.
- CLEAR_CNT  input  1  synchronous clear of LOCK_LOSS_CNT.
- FRAME  output  16  last aligned frame.
- FRAME_VALID  output  1  one-cycle strobe: FRAME holds a new frame.
- FRAME_IS_SYNC  output  1  qualifies FRAME_VALID; the frame equals SYNC_PATTERN.
- LOCKED  output  1  high while in LOCKED state.
- LOCK_LOSS_CNT  output  8  saturating count of LOCKED-to-HUNT transitions.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (CLK, RESETB). While RESETB=0 all outputs are 0, the shift register, phase and miss/sync counters are 0, and the state is HUNT. RESETB is taken asynchronously at any time, including mid-frame; alignment is lost and a full re-lock is required.
- Shift register: every edge, sr <= {sr[14:0], CMD_IN}. The first received bit is FRAME[15].
- Phase counter: 4 bits, counts bits since the last boundary, wraps 15->0. A boundary cycle is one in which sr holds a complete aligned frame.
- Output timing: all outputs are registered. If the last bit of a frame is sampled at edge n, FRAME/FRAME_VALID/FRAME_IS_SYNC are valid after edge n+1. FRAME_VALID is high for exactly one cycle. FRAME holds its value between strobes.
- HUNT state:
  - Compare sr with SYNC_PATTERN every cycle (any bit phase).
  - On a match, realign the phase so the next boundary falls exactly 16 cycles later, and set sync_cnt=1.
  - If LOCK_SYNCS=1, go to LOCKED; otherwise go to VERIFY.
  - No FRAME_VALID is emitted in HUNT.
- VERIFY state, evaluated at boundaries only:
  - sr==SYNC: increment sync_cnt; when sync_cnt reaches LOCK_SYNCS, go to LOCKED.
  - Any non-sync frame: return to HUNT and clear sync_cnt.
  - No FRAME_VALID is emitted in VERIFY, including for the sync frame that completes the lock.
- LOCKED state:
  - LOCKED=1 after the edge that enters the state.
  - At every boundary, emit FRAME_VALID with FRAME=sr.
  - Sync frame: miss_cnt=0 and FRAME_IS_SYNC=1.
  - Non-sync frame: miss_cnt+1. When miss_cnt reaches TIMEOUT_FRAMES, that frame is still emitted, then the state goes to HUNT. LOCKED falls on the same edge that raises that FRAME_VALID, and LOCK_LOSS_CNT increments on that edge.
  - A sync pattern seen at a non-boundary phase while LOCKED is ignored; there is no realignment without a timeout.
- LOCK_LOSS_CNT: saturates at 255. CLEAR_CNT=1 forces 0 on the next edge. CLEAR_CNT wins over a coincident increment.
- The first frame emitted after lock is the frame immediately following the LOCK_SYNCS-th sync.

Test Plan:
- Locking at an offset: reset, 5 random bits, then 0x817E repeated, with defaults → LOCKED rises 1 cycle after the last bit of the 16th sync. No FRAME_VALID before the 17th frame.
- Frame emission: when locked, send 0xA5A5, 0x817E, 0x1234 → three FRAME_VALID pulses 16 cycles apart with FRAME=0xA5A5/0x817E/0x1234 and FRAME_IS_SYNC=0/1/0.
- Timeout: when locked, send 32 frames of 0x6969 → 32 strobes. LOCKED falls with the 32nd strobe and LOCK_LOSS_CNT=1. A sync at the 31st frame instead resets miss_cnt, so LOCKED stays 1.
- Broken verify: 3 syncs, 0x0000, then 16 syncs → LOCKED stays 0 through the 0x0000 frame and rises only after the 16th sync of the second run.
- Bit slip: when locked, insert one extra bit then continuous syncs → garbage frames, and LOCKED drops after 32 frames. Re-lock occurs at the new phase after 16 further syncs. LOCK_LOSS_CNT=1.
- Reset and clear:
  - RESETB=0 for 3 cycles mid-frame while locked → all outputs 0 immediately (asynchronously). Re-lock needs 16 syncs.
  - Force 255 losses then one more → LOCK_LOSS_CNT stays 255.
  - CLEAR_CNT coincident with a loss → LOCK_LOSS_CNT=0.
